// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg : shared types and address-split helpers for dcache_responder    |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    WACK  = 2'd3
  } resp_state_t;

  // nlines is a power of two, so modulo/divide reduce to a bit split
  function automatic int unsigned idx_of(input int unsigned addr, input int unsigned nlines);
    return addr % nlines;
  endfunction

  function automatic int unsigned tag_of(input int unsigned addr, input int unsigned nbits,
                                         input int unsigned nlines);
    return (addr & ((32'd1 << nbits) - 32'd1)) / nlines;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_responder_if : data-memory request/response handshake             |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
interface dcache_responder_if #(
  parameter int NBITS = 8
);
  logic [NBITS-1:0] addr;
  logic [NBITS-1:0] wdata;
  logic             MemRead;
  logic             MemWrite;
  logic [NBITS-1:0] rdata;
  logic             busy;

  modport master (output addr, output wdata, output MemRead, output MemWrite,
                  input rdata, input busy);
  modport slave  (input addr, input wdata, input MemRead, input MemWrite,
                  output rdata, output busy);
endinterface
`default_nettype wire

// File: rtl/backing_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | backing_ram : 2**NBITS x NBITS RAM, synchronous write, async read        |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module backing_ram #(
  parameter int NBITS = 8
) (
  input  wire logic             clock,
  input  wire logic             we,
  input  wire logic [NBITS-1:0] waddr,
  input  wire logic [NBITS-1:0] wdata,
  input  wire logic [NBITS-1:0] raddr,
  output logic      [NBITS-1:0] rdata
);
  // Power-up contents are zero; reset never touches them
  logic [NBITS-1:0] r_mem [2**NBITS] = '{default: '0};

  always_ff @(posedge clock) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/dcache_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_responder : direct-mapped write-through, no-write-allocate cache  |
// |                    in front of a fixed-latency backing RAM               |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module dcache_responder
  import mem_pkg::*;
#(
  parameter int NBITS  = 8,
  parameter int NLINES = 8,
  parameter int LAT    = 3
) (
  input wire logic          clock,
  input wire logic          reset,
  dcache_responder_if.slave bus
);
  localparam int c_IDX_W = $clog2(NLINES);
  localparam int c_TAG_W = NBITS - c_IDX_W;
  localparam int c_CNT_W = $clog2(LAT) + 1;

  resp_state_t         r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [NBITS-1:0]    r_addr;
  logic [NBITS-1:0]    r_wdata;
  logic [NLINES-1:0]   r_valid;
  logic [c_TAG_W-1:0]  r_tag  [NLINES];
  logic [NBITS-1:0]    r_data [NLINES];

  logic [c_IDX_W-1:0]  w_idx, w_ridx;
  logic [c_TAG_W-1:0]  w_tag, w_rtag;
  logic                w_hit, w_busy, w_fill_done, w_write_done, w_ram_we;
  logic [NBITS-1:0]    w_rdata, w_ram_rdata;

  assign w_idx  = c_IDX_W'(idx_of(32'(bus.addr), NLINES));
  assign w_tag  = c_TAG_W'(tag_of(32'(bus.addr), NBITS, NLINES));
  assign w_ridx = c_IDX_W'(idx_of(32'(r_addr), NLINES));
  assign w_rtag = c_TAG_W'(tag_of(32'(r_addr), NBITS, NLINES));
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign w_fill_done  = (r_state == FILL)  && (r_cnt == '0);
  assign w_write_done = (r_state == WRITE) && (r_cnt == '0);
  // A reset landing on the final WRITE cycle abandons the RAM update
  assign w_ram_we     = w_write_done && !reset;

  backing_ram #(.NBITS(NBITS)) u_ram (
    .clock (clock),
    .we    (w_ram_we),
    .waddr (r_addr),
    .wdata (r_wdata),
    .raddr (r_addr),
    .rdata (w_ram_rdata)
  );

  always_comb begin
    w_busy  = 1'b0;
    w_rdata = '0;
    case (r_state)
      IDLE: begin
        if (bus.MemWrite)     w_busy  = 1'b1;
        else if (bus.MemRead) begin
          if (w_hit)          w_rdata = r_data[w_idx];
          else                w_busy  = 1'b1;
        end
      end
      FILL, WRITE: w_busy = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy  = w_busy;
  assign bus.rdata = w_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.MemWrite) begin
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_cnt   <= c_CNT_W'(LAT - 1);
            r_state <= WRITE;
          end else if (bus.MemRead && !w_hit) begin
            r_addr  <= bus.addr;
            r_cnt   <= c_CNT_W'(LAT - 1);
            r_state <= FILL;
          end
        end
        FILL: begin
          if (r_cnt == '0) begin
            r_valid[w_ridx] <= 1'b1;
            r_state         <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WRITE: begin
          if (r_cnt == '0) r_state <= WACK;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_fill_done) begin
        r_tag[w_ridx]  <= w_rtag;
        r_data[w_ridx] <= w_ram_rdata;
      end else if (w_write_done && r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag)) begin
        r_data[w_ridx] <= r_wdata;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dcache_responder : directed self-checking bench for dcache_responder  |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_dcache_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  dcache_responder_if #(.NBITS(8)) bus ();

  dcache_responder #(.NBITS(8), .NLINES(8), .LAT(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts busy cycles (bounded), then checks wait count and returned data
  task automatic do_read(input string tag, input logic [7:0] a,
                         input int exp_wait, input logic [7:0] exp_data);
    int n = 0;
    bus.addr    = a;
    bus.MemRead = 1'b1;
    @(negedge clock);
    while (bus.busy && n < 20) begin
      n++;
      tick();
      @(negedge clock);
    end
    check({tag, "_wait"}, n, exp_wait);
    check({tag, "_data"}, {24'd0, bus.rdata}, {24'd0, exp_data});
    tick();
    bus.MemRead = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d,
                          input logic also_read);
    int n = 0;
    bus.addr     = a;
    bus.wdata    = d;
    bus.MemWrite = 1'b1;
    bus.MemRead  = also_read;
    @(negedge clock);
    while (bus.busy && n < 20) begin
      n++;
      tick();
      @(negedge clock);
    end
    check({tag, "_busy"}, n, 4);
    check({tag, "_wack_rdata"}, {24'd0, bus.rdata}, 32'd0);
    tick();
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    @(negedge clock);
    check({tag, "_idle_after_wack"}, {31'd0, bus.busy}, 32'd0);
    tick();
  endtask

  initial begin
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_rdata", {24'd0, bus.rdata}, 32'd0);
    tick();

    // Cold miss, write-through on hit, then zero-wait hit
    do_read("cold_13", 8'h13, 4, 8'h00);
    do_write("wr_13", 8'h13, 8'hA5, 1'b0);
    do_read("hit_13", 8'h13, 0, 8'hA5);

    // Conflict: 0x1B shares index 3 with 0x13; write does not allocate
    do_write("wr_1b", 8'h1B, 8'h3C, 1'b0);
    do_read("hit_13_still", 8'h13, 0, 8'hA5);
    do_read("miss_1b", 8'h1B, 4, 8'h3C);
    do_read("remiss_13", 8'h13, 4, 8'hA5);
    do_read("rehit_13", 8'h13, 0, 8'hA5);

    // No-allocate on a cold line
    do_write("wr_42", 8'h42, 8'h7E, 1'b0);
    do_read("miss_42", 8'h42, 4, 8'h7E);
    do_read("hit_42", 8'h42, 0, 8'h7E);
    do_write("wr_42_hit", 8'h42, 8'h99, 1'b0);
    do_read("hit_42_upd", 8'h42, 0, 8'h99);

    // Both requests high is a write
    do_write("rw_05", 8'h05, 8'h11, 1'b1);
    do_read("miss_05", 8'h05, 4, 8'h11);

    // Reset in the 2nd FILL cycle
    bus.addr    = 8'h2A;
    bus.MemRead = 1'b1;
    tick();
    tick();
    reset       = 1'b1;
    bus.MemRead = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_fill_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_fill_rdata", {24'd0, bus.rdata}, 32'd0);
    tick();
    do_read("post_rst_13", 8'h13, 4, 8'hA5);
    do_read("post_rst_42", 8'h42, 4, 8'h99);

    // Reset on the last WRITE cycle abandons the RAM write
    bus.addr     = 8'h05;
    bus.wdata    = 8'h77;
    bus.MemWrite = 1'b1;
    tick();
    tick();
    tick();
    reset        = 1'b1;
    bus.MemWrite = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_write_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    do_read("abandon_05", 8'h05, 4, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dcache_responder.md
# dcache_responder

Memory-side responder for the processor's data-memory handshake (`MemRead`, `MemWrite`, `busy`). It holds a direct-mapped, write-through, no-write-allocate cache in front of a slow backing RAM with fixed latency. Read hits answer in the request cycle with `busy` low. Misses and all writes hold `busy` high while the backing RAM is accessed. It sits between the controller/datapath and the data memory, and is the only driver of `busy`.

## Interface
- `NBITS`, 8, data and address width; byte-addressed, one word per address
- `NLINES`, 8, number of cache lines; power of two, ≥2
- `LAT`, 3, backing-RAM access latency in cycles; ≥1
- `clock`  in  1  clock; all state changes on posedge
- `reset`  in  1  synchronous, active-high
- `addr`  in  NBITS  word address; stable while `busy`=1
- `wdata`  in  NBITS  write data; stable while `busy`=1
- `MemRead`  in  1  read request; held until `busy`=0
- `MemWrite`  in  1  write request; held until `busy`=0
- `rdata`  out  NBITS  read data; valid when `MemRead`=1 and `busy`=0
- `busy`  out  1  request not yet complete; requester must hold its request and stall

## Operation
- Address split: index = `addr[$clog2(NLINES)-1:0]`; tag = remaining upper bits.
- Each line holds: valid bit, tag, and data word.
- The backing RAM is 2**NBITS words and is initialised to 0.
- States:
  - IDLE
  - FILL: read miss in progress
  - WRITE: backing write in progress
  - WACK: write acknowledged
- `cnt` is a down-counter, width `$clog2(LAT)+1`.
- IDLE, no request: `busy`=0, `rdata`=0.
- IDLE, `MemRead`, hit: `busy`=0, `rdata`=line data (combinational). Stay in IDLE.
- IDLE, `MemRead`, miss: `busy`=1. Load `cnt`=LAT-1 and go to FILL.
- FILL: `busy`=1. Decrement `cnt`.
  - When `cnt`=0: write the line (valid=1, tag, data=RAM[addr]) and go to IDLE.
  - The held request then hits in IDLE.
- IDLE, `MemWrite`: `busy`=1. Load `cnt`=LAT-1 and go to WRITE.
  - `MemWrite` has priority when both requests are asserted.
- WRITE: `busy`=1. Decrement `cnt`.
  - When `cnt`=0: RAM[addr]←`wdata`. If the line is valid and the tag matches, line data←`wdata`; otherwise the line is untouched (no allocate). Go to WACK.
- WACK: `busy`=0 and all requests are ignored, so the held `MemWrite` is not re-issued. Go to IDLE unconditionally.
- Request dropped mid-FILL or mid-WRITE: protocol violation. The transaction still completes using the address latched at the IDLE→FILL/WRITE transition.
- `reset`:
  - State returns to IDLE and all valid bits clear.
  - `busy`=0, `rdata`=0.
  - RAM contents are preserved, and any in-flight RAM write is abandoned.

## Timing
- Read hit: 0 wait cycles; data is valid in the request cycle.
- Read miss: `busy` high for LAT+1 cycles (IDLE cycle + LAT FILL cycles); data is valid in the next cycle.
- Write: `busy` high for LAT+1 cycles; WACK is the completion cycle with `busy`=0.
- Back-to-back operations:
  - After a read hit, the next request is evaluated in the next cycle.
  - After WACK, the next request is evaluated in the next cycle.
- `addr` and `wdata` are registered at IDLE exit; FILL and WRITE use the registered copies.
- `busy` is combinational from state, `MemRead`, `MemWrite` and the hit signal, and has no dependency on `rdata`.

## Structure
- `mem_pkg`:
  - `resp_state_t` enum {IDLE, FILL, WRITE, WACK}
  - helper functions `idx_of(addr)` and `tag_of(addr)` parameterised by `NBITS`/`NLINES`
- Sub-module `backing_ram`: synchronous write, combinational read, `2**NBITS`×`NBITS`, no reset on contents.
- Tag/valid/data arrays are local to this block; valid bits are reset, tag and data arrays are not.

## Test plan
- Reset, then `MemRead` addr=0x13 (cold) → `busy`=1 for 4 cycles (LAT=3), then `rdata`=0x00 with `busy`=0.
- `MemWrite` addr=0x13, wdata=0xA5 → `busy`=1 for 4 cycles, then 1 WACK cycle with `busy`=0; the next `MemRead` 0x13 hits, 0 wait cycles, `rdata`=0xA5.
- Conflict: read 0x13 (fill), then read 0x1B (same index, different tag) → miss, 4 busy cycles, `rdata`=RAM[0x1B]; re-reading 0x13 misses again.
- No-allocate: write 0x42←0x7E on a cold line → RAM updated; a following read of 0x42 misses and returns 0x7E.
- `MemRead` and `MemWrite` both high, addr=0x05, wdata=0x11 → treated as a write (WACK is observed); a later read returns 0x11.
- `reset` asserted in the 2nd FILL cycle → next cycle `busy`=0, state IDLE; a previously cached address misses (valid bits cleared) while RAM data is intact.
